lu_sched: RTL and testbench

//  Sequencer and row store for the complex LU decomposition engine. Loads a SIZE x SIZE complex matrix from the host.

---
 rtl/lu_pkg.sv | 17 +
 rtl/lu_row_mem.sv | 41 ++++
 rtl/lu_sched.sv | 175 +++++++++++++++++
 tb/tb_lu_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared types and constants for the LU decomposition sequencer and its row store.
package lu_pkg;
    localparam int LU_SIZE = 16;
    localparam int ELEM_W  = 128;
    localparam int ROW_W   = LU_SIZE * ELEM_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Element [1] is the imaginary part and [0] the real part, both fp64.
    typedef logic [LU_SIZE-1:0][1:0][63:0] cplx_row_t;
endpackage

// File: rtl/lu_row_mem.sv
// Row store: one write port plus one synchronous read port.
// A read and a write to the same row in one cycle return the new row.
module lu_row_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic [AW-1:0]    rdata_addr,
    output logic             rvalid
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage carries no reset; contents are undefined until loaded.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid     <= 1'b0;
            rdata_addr <= '0;
            rdata      <= '0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata_addr <= raddr;
                rdata      <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
            end
        end
    end
endmodule

// File: rtl/lu_sched.sv
// Sequencer for the complex LU engine: loads the matrix, starts the core,
// serves its row traffic, forwards results to the host and reports completion.
// Valid/ready: a transfer happens on a rising edge where both are high; valid never waits on ready.
module lu_sched
    import lu_pkg::*;
#(
    parameter int SIZE      = LU_SIZE,
    parameter int WD_CYCLES = 4096,
    localparam int AW  = $clog2(SIZE),
    localparam int RW  = SIZE * ELEM_W,
    localparam int WDW = $clog2(WD_CYCLES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [RW-1:0] host_row_i,
    input  logic          host_row_valid_i,
    output logic          host_row_ready_o,
    input  logic          host_abort_i,
    output logic          lu_start_o,
    output logic          lu_flush_o,
    input  logic [AW-1:0] lu_rd_addr_i,
    input  logic          lu_rd_valid_i,
    output logic [RW-1:0] lu_row_o,
    output logic [AW-1:0] lu_row_addr_o,
    output logic          lu_row_valid_o,
    input  logic [RW-1:0] lu_wr_row_i,
    input  logic [AW-1:0] lu_wr_addr_i,
    input  logic          lu_wr_valid_i,
    output logic          lu_wr_ready_o,
    input  logic [RW-1:0] lu_res_l_i,
    input  logic [RW-1:0] lu_res_u_i,
    input  logic [AW-1:0] lu_res_addr_i,
    input  logic          lu_res_valid_i,
    output logic          lu_res_ready_o,
    output logic [RW-1:0] host_res_l_o,
    output logic [RW-1:0] host_res_u_o,
    output logic [AW-1:0] host_res_addr_o,
    output logic          host_res_valid_o,
    input  logic          host_res_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output state_t        dbg_state_o
);
    state_t           state_q, state_d;
    logic [AW-1:0]    load_ptr_q;
    logic [AW-1:0]    res_cnt_q;
    logic [WDW-1:0]   wd_cnt_q;
    logic             slice_full_q;
    logic [RW-1:0]    slice_l_q, slice_u_q;
    logic [AW-1:0]    slice_addr_q;
    logic             err_q;
    logic             flush_q;

    logic load_en, in_run, abort, load_hs, rd_hs, wr_hs, lu_res_hs, host_res_hs;
    logic lu_act, wd_expire, last_res, addr_err, run_hold;
    logic [AW-1:0] exp_idx;

    assign load_en     = (state_q == IDLE) || (state_q == LOAD);
    assign in_run      = (state_q == RUN);
    assign abort       = host_abort_i && (state_q != IDLE);
    assign load_hs     = host_row_valid_i && load_en;
    assign rd_hs       = lu_rd_valid_i && in_run;
    assign wr_hs       = lu_wr_valid_i && in_run;
    assign lu_res_hs   = lu_res_valid_i && lu_res_ready_o;
    assign host_res_hs = slice_full_q && host_res_ready_i;
    assign lu_act      = rd_hs || wr_hs || lu_res_hs;
    assign wd_expire   = in_run && !lu_act && (wd_cnt_q == WDW'(WD_CYCLES - 1));
    assign last_res    = host_res_hs && (res_cnt_q == AW'(SIZE - 2));
    // A result still parked in the slice has been accepted but not yet counted.
    assign exp_idx     = res_cnt_q + {{(AW-1){1'b0}}, slice_full_q};
    assign addr_err    = lu_res_hs && (lu_res_addr_i != exp_idx);
    assign run_hold    = in_run && (state_d == RUN);

    always_comb begin
        state_d    = state_q;
        lu_start_o = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            IDLE:    if (load_hs) state_d = LOAD;
            LOAD:    if (load_hs && (load_ptr_q == AW'(SIZE - 1))) state_d = START;
            START: begin
                lu_start_o = 1'b1;
                state_d    = RUN;
            end
            RUN:     if (last_res) state_d = DONE;
            DONE: begin
                done_o  = !host_abort_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort || wd_expire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            load_ptr_q   <= '0;
            res_cnt_q    <= '0;
            wd_cnt_q     <= '0;
            slice_full_q <= 1'b0;
            slice_l_q    <= '0;
            slice_u_q    <= '0;
            slice_addr_q <= '0;
            err_q        <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= abort || wd_expire;

            if (state_d == IDLE) begin
                load_ptr_q <= '0;
            end else if (load_hs) begin
                load_ptr_q <= load_ptr_q + 1'b1;
            end

            if (!run_hold) begin
                res_cnt_q    <= '0;
                wd_cnt_q     <= '0;
                slice_full_q <= 1'b0;
            end else begin
                if (host_res_hs) begin
                    res_cnt_q <= res_cnt_q + 1'b1;
                end
                wd_cnt_q <= lu_act ? '0 : wd_cnt_q + 1'b1;
                if (lu_res_hs) begin
                    slice_full_q <= 1'b1;
                    slice_l_q    <= lu_res_l_i;
                    slice_u_q    <= lu_res_u_i;
                    slice_addr_q <= lu_res_addr_i;
                end else if (host_res_hs) begin
                    slice_full_q <= 1'b0;
                end
            end

            if (wd_expire || addr_err) begin
                err_q <= 1'b1;
            end else if (load_hs && !abort) begin
                err_q <= 1'b0;
            end
        end
    end

    // Host loads and LU write-backs never overlap in time, so they share the write port.
    lu_row_mem #(
        .DEPTH(SIZE),
        .WIDTH(RW)
    ) u_row_mem (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we         (load_hs || wr_hs),
        .waddr      (load_hs ? load_ptr_q : lu_wr_addr_i),
        .wdata      (load_hs ? host_row_i : lu_wr_row_i),
        .re         (rd_hs),
        .raddr      (lu_rd_addr_i),
        .rdata      (lu_row_o),
        .rdata_addr (lu_row_addr_o),
        .rvalid     (lu_row_valid_o)
    );

    assign host_row_ready_o = load_en;
    assign lu_flush_o       = flush_q;
    assign lu_wr_ready_o    = in_run;
    assign lu_res_ready_o   = in_run && (!slice_full_q || host_res_ready_i);
    assign host_res_l_o     = slice_l_q;
    assign host_res_u_o     = slice_u_q;
    assign host_res_addr_o  = slice_addr_q;
    assign host_res_valid_o = slice_full_q;
    assign busy_o           = (state_q != IDLE);
    assign err_o            = err_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_lu_sched.sv
// Randomised scoreboard bench for lu_sched: expected reads and results are queued
// at issue time and popped by negedge monitors when the DUT presents them.
`timescale 1ns/1ps
module tb_lu_sched;
    import lu_pkg::*;

    localparam int SIZE = 16;
    localparam int AW   = 4;
    localparam int RW   = SIZE * 128;
    localparam int WD   = 4096;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [RW-1:0] host_row_i = '0;
    logic          host_row_valid_i = 1'b0;
    logic          host_row_ready_o;
    logic          host_abort_i = 1'b0;
    logic          lu_start_o, lu_flush_o;
    logic [AW-1:0] lu_rd_addr_i = '0;
    logic          lu_rd_valid_i = 1'b0;
    logic [RW-1:0] lu_row_o;
    logic [AW-1:0] lu_row_addr_o;
    logic          lu_row_valid_o;
    logic [RW-1:0] lu_wr_row_i = '0;
    logic [AW-1:0] lu_wr_addr_i = '0;
    logic          lu_wr_valid_i = 1'b0;
    logic          lu_wr_ready_o;
    logic [RW-1:0] lu_res_l_i = '0, lu_res_u_i = '0;
    logic [AW-1:0] lu_res_addr_i = '0;
    logic          lu_res_valid_i = 1'b0;
    logic          lu_res_ready_o;
    logic [RW-1:0] host_res_l_o, host_res_u_o;
    logic [AW-1:0] host_res_addr_o;
    logic          host_res_valid_o;
    logic          host_res_ready_i = 1'b0;
    logic          busy_o, done_o, err_o;
    state_t        dbg_state_o;

    lu_sched #(.SIZE(SIZE), .WD_CYCLES(WD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_row_i(host_row_i), .host_row_valid_i(host_row_valid_i), .host_row_ready_o(host_row_ready_o),
        .host_abort_i(host_abort_i), .lu_start_o(lu_start_o), .lu_flush_o(lu_flush_o),
        .lu_rd_addr_i(lu_rd_addr_i), .lu_rd_valid_i(lu_rd_valid_i),
        .lu_row_o(lu_row_o), .lu_row_addr_o(lu_row_addr_o), .lu_row_valid_o(lu_row_valid_o),
        .lu_wr_row_i(lu_wr_row_i), .lu_wr_addr_i(lu_wr_addr_i), .lu_wr_valid_i(lu_wr_valid_i),
        .lu_wr_ready_o(lu_wr_ready_o),
        .lu_res_l_i(lu_res_l_i), .lu_res_u_i(lu_res_u_i), .lu_res_addr_i(lu_res_addr_i),
        .lu_res_valid_i(lu_res_valid_i), .lu_res_ready_o(lu_res_ready_o),
        .host_res_l_o(host_res_l_o), .host_res_u_o(host_res_u_o), .host_res_addr_o(host_res_addr_o),
        .host_res_valid_o(host_res_valid_o), .host_res_ready_i(host_res_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0]        model_mem [SIZE];
    logic [AW+RW-1:0]     rd_q  [$];
    logic [AW+2*RW-1:0]   res_q [$];
    logic [AW+RW-1:0]     rd_e;
    logic [AW+2*RW-1:0]   res_e;
    int start_cyc = 0, flush_cyc = 0, done_cyc = 0;
    int fwd_cnt = 0, fwd_at_done = 0;
    logic busy_at_done = 1'b0;
    int hr_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        int bad;
        bad = -1;
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int i = SIZE - 1; i >= 0; i--)
                if (act[i*128 +: 128] !== exp[i*128 +: 128]) bad = i;
            $display("FAIL %s: element %0d got %h expected %h", name, bad,
                     act[bad*128 +: 128], exp[bad*128 +: 128]);
        end
    endtask

    function automatic logic [RW-1:0] const_row(input real v);
        logic [RW-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*128 +: 128] = {64'h0, $realtobits(v)};
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (lu_row_valid_o) begin
                if (rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL read_unexpected: addr %0d with nothing expected", lu_row_addr_o);
                end else begin
                    rd_e = rd_q.pop_front();
                    check("read_addr", 64'(lu_row_addr_o), 64'(rd_e[RW +: AW]));
                    check_row("read_data", lu_row_o, rd_e[RW-1:0]);
                end
            end
            if (host_res_valid_o && host_res_ready_i) begin
                if (res_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL result_unexpected: addr %0d with nothing expected", host_res_addr_o);
                end else begin
                    res_e = res_q.pop_front();
                    check("result_addr", 64'(host_res_addr_o), 64'(res_e[2*RW +: AW]));
                    check_row("result_l", host_res_l_o, res_e[RW +: RW]);
                    check_row("result_u", host_res_u_o, res_e[RW-1:0]);
                end
                fwd_cnt++;
            end
            if (lu_start_o) start_cyc++;
            if (lu_flush_o) flush_cyc++;
            if (done_o) begin
                done_cyc++;
                fwd_at_done  = fwd_cnt;
                busy_at_done = busy_o;
            end
        end
    end

    // Host result ready: random 50% or held high.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            host_res_ready_i = (hr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_job(input int n, input bit rnd);
        logic [RW-1:0] row;
        bit acc;
        int budget;
        for (int r = 0; r < n; r++) begin
            row = rnd ? rand_row() : const_row(real'(r) + 1.0);
            host_row_i = row;
            host_row_valid_i = 1'b1;
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 50) begin
                @(negedge clk_i);
                acc = host_row_ready_o;
                @(posedge clk_i);
                #1;
                budget++;
            end
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL load_timeout: row %0d not accepted, got ready 0 required 1", r);
            end
            model_mem[r] = row;
        end
        host_row_valid_i = 1'b0;
    endtask

    task automatic lu_cycle(input bit rd, input int ra, input bit wr, input int wa, input logic [RW-1:0] wrow);
        lu_rd_valid_i = rd;
        lu_rd_addr_i  = AW'(ra);
        lu_wr_valid_i = wr;
        lu_wr_addr_i  = AW'(wa);
        lu_wr_row_i   = wrow;
        if (wr) check("wr_ready", 64'(lu_wr_ready_o), 64'd1);
        if (rd) rd_q.push_back({AW'(ra), (wr && wa == ra) ? wrow : model_mem[ra]});
        if (wr) model_mem[wa] = wrow;
        tick();
        lu_rd_valid_i = 1'b0;
        lu_wr_valid_i = 1'b0;
    endtask

    task automatic send_res(input int k);
        logic [RW-1:0] l, u;
        bit acc;
        int budget;
        l = rand_row();
        u = rand_row();
        lu_res_l_i = l;
        lu_res_u_i = u;
        lu_res_addr_i = AW'(k);
        lu_res_valid_i = 1'b1;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 100) begin
            @(negedge clk_i);
            acc = lu_res_ready_o;
            @(posedge clk_i);
            #1;
            budget++;
        end
        lu_res_valid_i = 1'b0;
        if (acc) res_q.push_back({AW'(k), l, u});
        else begin
            n_checks++; n_fail++;
            $display("FAIL result_timeout: addr %0d not accepted, got ready 0 required 1", k);
        end
    endtask

    task automatic wait_done();
        int d0, budget;
        d0 = done_cyc;
        budget = 0;
        while (done_cyc == d0 && budget < 300) begin
            tick();
            budget++;
        end
        check("done_pulses", 64'(done_cyc - d0), 64'd1);
        check("fwd_at_done", 64'(fwd_at_done), 64'(SIZE - 1));
        check("busy_during_done", 64'(busy_at_done), 64'd1);
        check("busy_after_done", 64'(busy_o), 64'd0);
        check("done_after_done", 64'(done_o), 64'd0);
        check("res_queue_empty", 64'(res_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, d0, f0;
        bit exp_err;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_row_ready", 64'(host_row_ready_o), 64'd1);
        check("rst_start", 64'(lu_start_o), 64'd0);
        check("rst_flush", 64'(lu_flush_o), 64'd0);
        check("rst_row_valid", 64'(lu_row_valid_o), 64'd0);
        check("rst_wr_ready", 64'(lu_wr_ready_o), 64'd0);
        check("rst_res_ready", 64'(lu_res_ready_o), 64'd0);
        check("rst_res_valid", 64'(host_res_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Job 1: constant rows, directed reads/writes, random traffic, results
        load_job(SIZE, 1'b0);
        check("ready_after_load", 64'(host_row_ready_o), 64'd0);
        check("start_after_load", 64'(lu_start_o), 64'd1);
        check("busy_in_job", 64'(busy_o), 64'd1);
        tick();
        check("start_one_cycle", 64'(lu_start_o), 64'd0);
        lu_cycle(1'b1, 5, 1'b0, 0, '0);
        check_row("row5_is_6", model_mem[5], const_row(6.0));
        tick();
        lu_cycle(1'b1, 5, 1'b1, 5, const_row(9.0));
        lu_cycle(1'b1, 5, 1'b0, 0, '0);
        for (int i = 0; i < 40; i++)
            lu_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, SIZE - 1)),
                     ($urandom_range(0, 3) == 0), int'($urandom_range(0, SIZE - 1)), rand_row());
        tick();
        check("read_queue_empty", 64'(rd_q.size()), 64'd0);
        fwd_cnt = 0;
        for (int k = 0; k < SIZE - 1; k++) begin
            send_res(k);
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_done();
        check("err_clean_job", 64'(err_o), 64'd0);

        // Job 2: result index 3 arrives where 2 is expected
        load_job(SIZE, 1'b1);
        tick();
        fwd_cnt = 0;
        exp_err = 1'b0;
        for (int k = 0; k < SIZE - 1; k++) begin
            n = (k < 2) ? k : k + 1;
            if (n != k) exp_err = 1'b1;
            send_res(n);
            if (k == 2) begin
                tick();
                check("err_bad_index", 64'(err_o), 64'(exp_err));
            end
        end
        wait_done();
        check("err_sticky_idle", 64'(err_o), 64'd1);

        // Job 3: next load clears the error, then the LU stalls
        load_job(SIZE, 1'b1);
        check("err_cleared_by_load", 64'(err_o), 64'd0);
        tick();
        f0 = flush_cyc;
        n = 0;
        while (flush_cyc == f0 && n < WD + 50) begin
            tick();
            n++;
        end
        check("wd_flush_seen", 64'(flush_cyc - f0), 64'd1);
        check("wd_latency_ok", 64'(n >= WD - 2 && n <= WD + 3), 64'd1);
        check("wd_err", 64'(err_o), 64'd1);
        check("wd_state_idle", 64'(dbg_state_o), 64'(IDLE));
        check("wd_busy", 64'(busy_o), 64'd0);
        check("wd_row_ready", 64'(host_row_ready_o), 64'd1);
        check("wd_flush_one_cycle", 64'(lu_flush_o), 64'd0);

        // Job 4: abort during load after 7 rows
        load_job(7, 1'b1);
        check("err_cleared_partial", 64'(err_o), 64'd0);
        d0 = done_cyc;
        host_abort_i = 1'b1;
        tick();
        host_abort_i = 1'b0;
        check("abort_load_flush", 64'(lu_flush_o), 64'd1);
        check("abort_load_busy", 64'(busy_o), 64'd0);
        check("abort_load_ready", 64'(host_row_ready_o), 64'd1);
        tick();
        check("abort_load_flush_off", 64'(lu_flush_o), 64'd0);

        // Job 5: abort coincides with the final result handshake
        hr_mode = 1;
        load_job(SIZE, 1'b0);
        tick();
        fwd_cnt = 0;
        for (int k = 0; k < SIZE - 1; k++) send_res(k);
        host_abort_i = 1'b1;
        tick();
        host_abort_i = 1'b0;
        check("abort_final_flush", 64'(lu_flush_o), 64'd1);
        check("abort_final_busy", 64'(busy_o), 64'd0);
        repeat (5) tick();
        check("abort_no_done", 64'(done_cyc - d0), 64'd0);
        check("abort_final_fwd", 64'(fwd_cnt), 64'(SIZE - 1));
        hr_mode = 0;

        // Job 6: clean run after aborts
        load_job(SIZE, 1'b0);
        tick();
        for (int i = 0; i < 12; i++)
            lu_cycle(1'b1, int'($urandom_range(0, SIZE - 1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, SIZE - 1)), rand_row());
        fwd_cnt = 0;
        for (int k = 0; k < SIZE - 1; k++) send_res(k);
        wait_done();
        check("final_err", 64'(err_o), 64'd0);
        check("final_read_queue", 64'(rd_q.size()), 64'd0);

        repeat (3) tick();
        check("total_start_cycles", 64'(start_cyc), 64'd5);
        check("total_flush_cycles", 64'(flush_cyc), 64'd3);
        check("total_done_cycles", 64'(done_cyc), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
